// File: rtl/uart_par_pkg.sv
// Shared parity types and the parity function used by both the TX and RX paths.
package uart_par_pkg;

  typedef enum logic [1:0] {
    PAR_EVEN  = 2'b00,
    PAR_ODD   = 2'b01,
    PAR_MARK  = 2'b10,
    PAR_SPACE = 2'b11
  } par_mode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ACCUM = 2'b01,
    CHECK = 2'b10
  } rx_state_t;

  // xor_reduced is the XOR of all data bits; the result is the parity bit to send or expect.
  function automatic logic par_calc(bit xor_reduced, par_mode_t mode);
    logic p;
    case (mode)
      PAR_EVEN:  p = xor_reduced;
      PAR_ODD:   p = ~xor_reduced;
      PAR_MARK:  p = 1'b1;
      default:   p = 1'b0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/uart_par_rx_chk.sv
// RX parity checker: serial accumulation over data bits, check of the parity bit,
// and a saturating error counter.
module uart_par_rx_chk
  import uart_par_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 Par_En,
  input  logic [1:0]           Par_Typ,
  input  logic                 Frame_Start,
  input  logic                 Samp_Valid,
  input  logic                 Samp_Bit,
  input  logic                 Err_Clr,
  output logic                 rx_done,
  output logic                 par_err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0]     LAST    = CNT_W'(DATA_WIDTH - 1);
  localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

  rx_state_t        state;
  logic             acc;
  logic [CNT_W-1:0] cnt;
  logic             mode_en;
  par_mode_t        mode_typ;
  logic             err_hit;

  // Frame_Start overrides any sample taken in the same cycle.
  assign err_hit = !Frame_Start && (state == CHECK) && Samp_Valid &&
                   (Samp_Bit != par_calc(acc, mode_typ));

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state    <= IDLE;
      acc      <= 1'b0;
      cnt      <= '0;
      mode_en  <= 1'b0;
      mode_typ <= PAR_EVEN;
      rx_done  <= 1'b0;
      par_err  <= 1'b0;
    end else begin
      // NOTE: non-blocking here so every register samples pre-edge values; a blocking
      // update of cnt would make the LAST compare see the incremented value.
      rx_done <= 1'b0;
      par_err <= 1'b0;
      if (Frame_Start) begin
        state    <= ACCUM;
        acc      <= 1'b0;
        cnt      <= '0;
        mode_en  <= Par_En;
        mode_typ <= par_mode_t'(Par_Typ);
      end else begin
        case (state)
          IDLE: begin
            acc <= 1'b0;
            cnt <= '0;
          end
          ACCUM: begin
            if (Samp_Valid) begin
              acc <= acc ^ Samp_Bit;
              cnt <= cnt + 1'b1;
              if (cnt == LAST) begin
                if (mode_en) begin
                  state <= CHECK;
                end else begin
                  state   <= IDLE;
                  rx_done <= 1'b1;
                end
              end
            end
          end
          CHECK: begin
            if (Samp_Valid) begin
              state   <= IDLE;
              rx_done <= 1'b1;
              par_err <= err_hit;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Clear takes effect first, so a coincident error leaves the count at 1.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      err_cnt <= '0;
    end else if (Err_Clr) begin
      err_cnt <= ERR_CNT_W'(err_hit);
    end else if (err_hit && (err_cnt != ERR_MAX)) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_parity_unit.sv
// UART parity unit: registered TX parity bit for a parallel word plus the RX checker.
module uart_parity_unit
  import uart_par_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  Par_En,
  input  logic [1:0]            Par_Typ,
  input  logic [DATA_WIDTH-1:0] P_Data,
  input  logic                  Data_Valid,
  output logic                  par_bit,
  input  logic                  Frame_Start,
  input  logic                  Samp_Valid,
  input  logic                  Samp_Bit,
  input  logic                  Err_Clr,
  output logic                  rx_done,
  output logic                  par_err,
  output logic [ERR_CNT_W-1:0]  err_cnt
);

  always_ff @(posedge CLK) begin
    if (!RST) begin
      par_bit <= 1'b0;
    end else if (Data_Valid) begin
      par_bit <= Par_En ? par_calc(^P_Data, par_mode_t'(Par_Typ)) : 1'b0;
    end
  end

  uart_par_rx_chk #(
    .DATA_WIDTH(DATA_WIDTH),
    .ERR_CNT_W (ERR_CNT_W)
  ) u_rx (
    .CLK        (CLK),
    .RST        (RST),
    .Par_En     (Par_En),
    .Par_Typ    (Par_Typ),
    .Frame_Start(Frame_Start),
    .Samp_Valid (Samp_Valid),
    .Samp_Bit   (Samp_Bit),
    .Err_Clr    (Err_Clr),
    .rx_done    (rx_done),
    .par_err    (par_err),
    .err_cnt    (err_cnt)
  );

endmodule

// File: tb/tb_uart_parity_unit.sv
// Directed bench for uart_parity_unit: TX vector table plus hand-written RX frame sequences.
module tb_uart_parity_unit;
  import uart_par_pkg::*;

  logic       CLK = 1'b0;
  logic       RST;
  logic       Par_En;
  logic [1:0] Par_Typ;
  logic [7:0] P_Data;
  logic       Data_Valid;
  logic       par_bit;
  logic       Frame_Start;
  logic       Samp_Valid;
  logic       Samp_Bit;
  logic       Err_Clr;
  logic       rx_done;
  logic       par_err;
  logic [7:0] err_cnt;

  int tests = 0;
  int fails = 0;

  always #5 CLK = ~CLK;

  uart_parity_unit #(.DATA_WIDTH(8), .ERR_CNT_W(8)) u_dut (
    .CLK        (CLK),
    .RST        (RST),
    .Par_En     (Par_En),
    .Par_Typ    (Par_Typ),
    .P_Data     (P_Data),
    .Data_Valid (Data_Valid),
    .par_bit    (par_bit),
    .Frame_Start(Frame_Start),
    .Samp_Valid (Samp_Valid),
    .Samp_Bit   (Samp_Bit),
    .Err_Clr    (Err_Clr),
    .rx_done    (rx_done),
    .par_err    (par_err),
    .err_cnt    (err_cnt)
  );

  typedef struct {
    logic       en;
    logic [1:0] typ;
    logic [7:0] data;
    logic       dv;
    logic       exp;
  } tx_vec_t;

  tx_vec_t tx_vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one edge; outputs are then read 1 time unit after it.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One full RX frame starting with Frame_Start; data sent LSB first.
  task automatic run_frame(input string name, input logic [7:0] data, input logic pbit,
                           input logic en, input logic [1:0] typ, input logic exp_err,
                           input bit clr_last, input bit quiet);
    logic early;
    early       = 1'b0;
    Par_En      = en;
    Par_Typ     = typ;
    Frame_Start = 1'b1;
    Samp_Valid  = 1'b0;
    tick();
    Frame_Start = 1'b0;
    if (!quiet) check({name, " start_quiet"}, {30'd0, rx_done, par_err}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      Samp_Valid = 1'b1;
      Samp_Bit   = data[i];
      if (!en && i == 7) Err_Clr = clr_last;
      tick();
      if ((i < 7 || en) && (rx_done || par_err)) early = 1'b1;
    end
    if (en) begin
      Samp_Bit = pbit;
      Err_Clr  = clr_last;
      tick();
    end
    Samp_Valid = 1'b0;
    Err_Clr    = 1'b0;
    if (!quiet) begin
      check({name, " no_early"}, {31'd0, early}, 32'd0);
      check({name, " rx_done"}, {31'd0, rx_done}, 32'd1);
      check({name, " par_err"}, {31'd0, par_err}, {31'd0, exp_err});
    end
  endtask

  initial begin
    // en, typ, data, dv, expected par_bit after the edge
    tx_vecs[0] = '{1'b1, 2'b00, 8'hA5, 1'b1, 1'b0};
    tx_vecs[1] = '{1'b1, 2'b01, 8'hA5, 1'b1, 1'b1};
    tx_vecs[2] = '{1'b1, 2'b00, 8'h00, 1'b0, 1'b1}; // hold
    tx_vecs[3] = '{1'b1, 2'b10, 8'hA5, 1'b1, 1'b1};
    tx_vecs[4] = '{1'b0, 2'b10, 8'hFF, 1'b1, 1'b0}; // disabled
    tx_vecs[5] = '{1'b1, 2'b11, 8'hA5, 1'b1, 1'b0};
    tx_vecs[6] = '{1'b1, 2'b00, 8'h07, 1'b1, 1'b1};
    tx_vecs[7] = '{1'b1, 2'b01, 8'h07, 1'b1, 1'b0};
    tx_vecs[8] = '{1'b1, 2'b00, 8'hFF, 1'b0, 1'b0}; // hold

    RST = 1'b0; Par_En = 1'b0; Par_Typ = 2'b00; P_Data = 8'h00; Data_Valid = 1'b0;
    Frame_Start = 1'b0; Samp_Valid = 1'b0; Samp_Bit = 1'b0; Err_Clr = 1'b0;
    tick();
    tick();
    check("reset par_bit", {31'd0, par_bit}, 32'd0);
    check("reset rx_done", {31'd0, rx_done}, 32'd0);
    check("reset par_err", {31'd0, par_err}, 32'd0);
    check("reset err_cnt", {24'd0, err_cnt}, 32'd0);
    RST = 1'b1;
    tick();

    for (int i = 0; i < 9; i++) begin
      Par_En = tx_vecs[i].en; Par_Typ = tx_vecs[i].typ;
      P_Data = tx_vecs[i].data; Data_Valid = tx_vecs[i].dv;
      tick();
      check($sformatf("tx vec%0d", i), {31'd0, par_bit}, {31'd0, tx_vecs[i].exp});
    end
    Data_Valid = 1'b0;

    // 8'h07 has odd weight: even expects 1, odd expects 0.
    run_frame("good_even", 8'h07, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
    check("good_even err_cnt", {24'd0, err_cnt}, 32'd0);
    run_frame("bad_odd", 8'h07, 1'b1, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0);
    check("bad_odd err_cnt", {24'd0, err_cnt}, 32'd1);
    tick();
    check("pulse one cycle", {30'd0, rx_done, par_err}, 32'd0);

    for (int i = 0; i < 259; i++)
      run_frame("sat", 8'h07, 1'b1, 1'b1, 2'b01, 1'b1, 1'b0, 1'b1);
    check("saturated err_cnt", {24'd0, err_cnt}, 32'd255);

    Err_Clr = 1'b1;
    tick();
    Err_Clr = 1'b0;
    check("err_clr", {24'd0, err_cnt}, 32'd0);

    run_frame("clr_with_err", 8'h07, 1'b1, 1'b1, 2'b01, 1'b1, 1'b1, 1'b0);
    check("clr_with_err err_cnt", {24'd0, err_cnt}, 32'd1);

    // Abort after 4 bits (odd weight so a stale acc would flip the check).
    Par_En = 1'b1; Par_Typ = 2'b00; Frame_Start = 1'b1;
    tick();
    Frame_Start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      Samp_Valid = 1'b1;
      Samp_Bit   = (i != 1);
      tick();
    end
    Samp_Valid = 1'b0;
    check("abort no pulse", {30'd0, rx_done, par_err}, 32'd0);
    run_frame("after_abort", 8'h07, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
    check("after_abort err_cnt", {24'd0, err_cnt}, 32'd1);

    // Frame_Start with a valid '1' sample: the sample must be dropped.
    Par_En = 1'b1; Par_Typ = 2'b00; Frame_Start = 1'b1; Samp_Valid = 1'b1; Samp_Bit = 1'b1;
    tick();
    Frame_Start = 1'b0;
    begin
      logic early_c;
      early_c = 1'b0;
      for (int i = 0; i < 8; i++) begin
        Samp_Bit = 1'b0;
        tick();
        if (rx_done || par_err) early_c = 1'b1;
      end
      check("collision no_early", {31'd0, early_c}, 32'd0);
    end
    Samp_Bit = 1'b0;
    tick();
    Samp_Valid = 1'b0;
    check("collision rx_done", {31'd0, rx_done}, 32'd1);
    check("collision par_err", {31'd0, par_err}, 32'd0);

    // Par_Typ switched to odd mid-frame; latched even must apply.
    Par_En = 1'b1; Par_Typ = 2'b00; Frame_Start = 1'b1;
    tick();
    Frame_Start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin Par_Typ = 2'b01; Par_En = 1'b0; end
      Samp_Valid = 1'b1;
      Samp_Bit   = (i < 3);
      tick();
    end
    Samp_Bit = 1'b1;
    tick();
    Samp_Valid = 1'b0;
    check("latched mode rx_done", {31'd0, rx_done}, 32'd1);
    check("latched mode par_err", {31'd0, par_err}, 32'd0);

    // Parity disabled: done after 8 samples, 9th sample ignored in IDLE.
    run_frame("disabled", 8'h07, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0);
    Samp_Valid = 1'b1; Samp_Bit = 1'b1;
    tick();
    Samp_Valid = 1'b0;
    check("disabled 9th ignored", {30'd0, rx_done, par_err}, 32'd0);
    tick();
    check("disabled still idle", {30'd0, rx_done, par_err}, 32'd0);
    check("disabled err_cnt", {24'd0, err_cnt}, 32'd1);

    // Reset while in CHECK with a wrong parity bit presented.
    Par_En = 1'b1; Par_Typ = 2'b00; Frame_Start = 1'b1;
    tick();
    Frame_Start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      Samp_Valid = 1'b1;
      Samp_Bit   = (i < 3);
      tick();
    end
    RST = 1'b0; Samp_Bit = 1'b0;
    tick();
    check("rst_check outputs", {22'd0, rx_done, par_err, err_cnt}, 32'd0);
    check("rst_check state", 32'(u_dut.u_rx.state), 32'(IDLE));
    RST = 1'b1; Samp_Bit = 1'b1;
    tick();
    Samp_Valid = 1'b0;
    check("post_rst idle sample", {30'd0, rx_done, par_err}, 32'd0);
    run_frame("post_rst", 8'h07, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0);
    check("post_rst err_cnt", {24'd0, err_cnt}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_parity_unit.md
# uart_parity_unit

Parametrised parity block shared by the UART TX and RX paths. The TX side registers a parity bit for a parallel data word. The RX side accumulates parity serially over sampled data bits, checks the received parity bit, and keeps a saturating error count. It supports four parity modes and any data width, and replaces the fixed 8-bit even/odd TX-only calculator.

## Interface
Parameters:
- DATA_WIDTH, 8, data bits per frame (1..16)
- ERR_CNT_W, 8, width of the saturating parity-error counter

Ports:
- CLK  in  1  clock
- RST  in  1  reset, synchronous, active-low
- Par_En  in  1  parity enabled; when 0, no parity bit is generated or checked
- Par_Typ  in  2  parity mode: 00 even, 01 odd, 10 mark (always 1), 11 space (always 0)
- P_Data  in  DATA_WIDTH  TX parallel word
- Data_Valid  in  1  TX load strobe for P_Data
- par_bit  out  1  registered TX parity bit
- Frame_Start  in  1  RX start-bit detected; begins a new frame
- Samp_Valid  in  1  RX sampled bit is valid this cycle
- Samp_Bit  in  1  RX sampled bit value
- Err_Clr  in  1  clears err_cnt
- rx_done  out  1  one-cycle pulse when a frame's data and parity are fully consumed
- par_err  out  1  one-cycle pulse, coincident with rx_done, on parity mismatch
- err_cnt  out  ERR_CNT_W  saturating count of par_err pulses

## Operation
TX path:
- On Data_Valid with Par_En=1, par_bit <= f(P_Data, Par_Typ):
  - even: ^P_Data
  - odd: ~^P_Data
  - mark: 1
  - space: 0
- On Data_Valid with Par_En=0, par_bit <= 0.
- When Data_Valid=0, par_bit holds its value.
- Par_Typ is sampled only on Data_Valid.

RX FSM, with states IDLE, ACCUM, CHECK:
- IDLE:
  - Frame_Start -> ACCUM.
  - Clear acc to 0 and cnt to 0.
  - Latch Par_En and Par_Typ into mode registers. A mid-frame change of Par_Typ or Par_En has no effect on the current frame.
- ACCUM:
  - Each Samp_Valid: acc <= acc ^ Samp_Bit, cnt <= cnt+1.
  - On the sample that makes cnt == DATA_WIDTH:
    - latched Par_En=1 -> CHECK;
    - latched Par_En=0 -> IDLE and pulse rx_done (par_err=0).
- CHECK:
  - First Samp_Valid is the parity bit.
  - Expected bit = f over acc with the latched mode: even acc, odd ~acc, mark 1, space 0.
  - Pulse rx_done. Pulse par_err if Samp_Bit != expected. Go to IDLE.
- Frame_Start in any state aborts the current frame without rx_done or par_err, then re-initialises as from IDLE (restart).
- Frame_Start and Samp_Valid in the same cycle: Frame_Start wins and the sample is discarded.

Counters and widths:
- cnt width is $clog2(DATA_WIDTH+1).
- err_cnt increments on each par_err and saturates at 2^ERR_CNT_W-1.
- Err_Clr alone -> 0.
- Err_Clr together with par_err -> 1; the increment is applied after the clear.

## Timing
- Reset (RST=0 at a CLK edge) values:
  - par_bit=0, rx_done=0, par_err=0, err_cnt=0
  - FSM=IDLE, acc=0, cnt=0
  - latched mode = even/disabled
- Reset mid-frame discards the frame with no pulses.
- TX latency: 1 cycle. par_bit is valid on the edge after the Data_Valid edge.
- RX latency: rx_done/par_err assert in the cycle after the edge that captured the final sample (registered outputs) and last exactly 1 cycle.
- err_cnt updates on the same edge as the par_err assertion.
- Samp_Valid may arrive on any cycle and needs no minimum spacing; back-to-back samples are accepted every cycle.
- A sample arriving in IDLE is ignored.
- Back-to-back frames: Frame_Start is accepted in the same cycle that rx_done is high.

## Structure
- Package uart_par_pkg:
  - par_mode_t enum (PAR_EVEN=2'b00, PAR_ODD=2'b01, PAR_MARK=2'b10, PAR_SPACE=2'b11)
  - rx_state_t enum (IDLE, ACCUM, CHECK)
  - function par_calc(bit xor_reduced, par_mode_t mode), used by both paths
- Sub-module uart_par_rx_chk holds the RX FSM, accumulator, bit counter and error counter.
- Top uart_parity_unit holds the TX register and one uart_par_rx_chk instance.

## Test plan
All scenarios use DATA_WIDTH=8 and ERR_CNT_W=8.
- TX modes: P_Data=8'hA5 (even weight) with Data_Valid in each mode -> par_bit = 0 (even), 1 (odd), 1 (mark), 0 (space). Par_En=0 -> 0. par_bit holds while Data_Valid=0.
- RX good frame: even mode, Frame_Start, then bits of 8'h07 LSB first, then parity 1 -> rx_done pulse, par_err=0, err_cnt=0.
- RX bad frame and saturation:
  - odd mode, data 8'h07, parity 1 -> par_err pulse with rx_done, err_cnt=1.
  - 260 bad frames -> err_cnt=255 (saturated).
  - Err_Clr -> 0.
  - Err_Clr together with par_err -> 1.
- Abort and collisions:
  - Frame_Start after 4 data bits -> no pulses, and the next full frame checks correctly.
  - Frame_Start with Samp_Valid in the same cycle -> that sample is not counted.
  - Par_Typ toggled mid-frame -> the latched mode is used.
- Parity disabled: Par_En=0 at Frame_Start -> rx_done after 8 samples, the 9th sample is ignored in IDLE, par_err never asserts.
- Reset: RST=0 in CHECK -> all outputs 0 and FSM=IDLE; a later frame behaves normally.
